word_encoder_seq: RTL and testbench
===================================

# word_encoder_seq

Serialiser that is the inverse of the cache word-enable decode path. It takes an 8-bit word-enable mask for one cache line and emits, one per handshake, the 3-bit word address codes of every set bit in ascending order. The cache controller uses it to drive per-word writeback and refill sequencing toward memory. The code convention is shared with the decode path: mask bit k (k = 0..6) corresponds to address code k+1, and code 0 means "no word".

## Interface
- Parameters: none. Width constants come from the shared package.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `load_valid`  in  1  a new mask is offered.
- `load_mask`  in  8  word-enable mask. Bit 7 has no address code and is discarded at load.
- `load_ready`  out  1  block can accept a mask; high only in IDLE.
- `flush`  in  1  synchronous abort of the current sequence.
- `out_valid`  out  1  `out_addr` holds a valid word code.
- `out_ready`  in  1  consumer accepts `out_addr`.
- `out_addr`  out  3  word address code, 1..7. It is 0 whenever `out_valid` = 0.
- `out_last`  out  1  the current `out_addr` is the final word of the sequence.
- `remaining`  out  3  count of set bits still pending, including the one on `out_addr`.
- `done`  out  1  one-cycle pulse when a sequence completes normally.
- `bad_bit7`  out  1  one-cycle pulse, issued with the load, when `load_mask[7]` was set.

## Operation
- State machine with two states: IDLE and RUN. A 7-bit register `pend` holds the pending bits.
- Reset: state = IDLE, `pend` = 0. After reset, all outputs are 0 except `load_ready` = 1.
- IDLE:
  - `load_ready` = 1.
  - On `load_valid` & `load_ready`, `pend` <= `load_mask[6:0]`.
  - If `load_mask[6:0]` is nonzero, go to RUN.
  - Otherwise stay in IDLE and pulse `done` on the next cycle. This is the empty-line case.
- RUN:
  - `out_valid` = 1.
  - `out_addr` = (index of the lowest set bit of `pend`) + 1.
  - `out_last` = 1 when popcount(`pend`) = 1.
  - `remaining` = popcount(`pend`).
- Transfer: on `out_valid` & `out_ready`, the lowest set bit of `pend` is cleared. If `out_last` was 1, go to IDLE and pulse `done` on the next cycle.
- Holding: when `out_ready` = 0, `out_addr`, `out_last` and `remaining` stay stable. No bit is dropped.
- `flush` in RUN: `pend` <= 0 and state goes to IDLE on the next cycle. No `done`.
  - `flush` has priority over a simultaneous transfer. That word counts as not transferred.
  - `flush` in IDLE: ignored, and a simultaneous load still proceeds.
- `rst` asserted in any state, including mid-sequence: behaves as reset. No `done`, no pending output.
- `load_valid` while in RUN: ignored (`load_ready` = 0). The mask is not latched.

## Timing
- Load accepted in cycle N gives `out_valid` = 1 in cycle N+1. Its `out_addr` is the lowest code.
- With `out_ready` held high, codes stream at one per cycle. A mask with p set bits gives:
  - last transfer in cycle N+p;
  - `done` in cycle N+p+1;
  - `load_ready` = 1 again in cycle N+p+1.
- Empty mask loaded in cycle N: `done` in cycle N+1 and `load_ready` stays 1 throughout.
- `out_addr`, `out_last` and `remaining` are combinational from `pend`. `done` and `bad_bit7` are registered.
- A new load is not accepted in the same cycle as the final transfer.

## Structure
- Shared package `word_pkg`:
  - `WORDS` = 8;
  - `WADDR_W` = 3;
  - `WORD_NONE` = 3'd0;
  - state enum {IDLE, RUN}.
- The decode path also adopts `word_pkg`, so that bit k ↔ code k+1 is defined in one place.
- One sub-module, `word_prienc`: 7-bit lowest-set-bit priority encoder.
  - Outputs: code 1..7, or 0 for an empty input, plus a one-hot clear mask.
  - The popcount stays inline in the parent.

## Test plan
- Reset, then load mask 8'h00 with `out_ready` = 1:
  - no `out_valid`;
  - `done` pulses the cycle after the load;
  - `load_ready` stays 1.
- Load 8'h25 with `out_ready` = 1:
  - `out_addr` = 1, 3, 6 on consecutive cycles;
  - `remaining` = 3, 2, 1;
  - `out_last` only on 6;
  - `done` one cycle after code 6.
- Load 8'h7F with `out_ready` toggling 1,0,1,0…:
  - codes 1..7, each held stable while stalled;
  - 7 transfers total, then `done`.
- Load 8'h81:
  - `bad_bit7` pulses once;
  - a single code 1 with `out_last` = 1;
  - then `done`.
- Load 8'h0E, accept code 2, then assert `flush` together with `out_ready` while code 3 is shown:
  - next cycle is IDLE, with `out_valid` = 0 and no `done`;
  - a new load of 8'h40 then yields code 7.
- Load 8'h18, then assert `rst` after the first transfer:
  - next cycle, all outputs are at reset values (`load_ready` = 1);
  - no `done`;
  - `load_valid` while in RUN was ignored throughout.

Source files
------------

// File: rtl/word_pkg.sv
// rtl/word_pkg.sv - shared word-enable / word-address constants and state type
package word_pkg;

    localparam int WORDS   = 8;
    localparam int WADDR_W = 3;
    // Only bits 0..6 carry an address code; bit k maps to code k+1.
    localparam int PEND_W  = WORDS - 1;

    localparam logic [WADDR_W-1:0] WORD_NONE = 3'd0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/word_prienc.sv
// rtl/word_prienc.sv - lowest-set-bit priority encoder with one-hot clear mask
module word_prienc
    import word_pkg::*;
(
    input  logic [PEND_W-1:0]  vec,
    output logic [WADDR_W-1:0] code,
    output logic [PEND_W-1:0]  clr
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        code = WORD_NONE;
        for (int i = PEND_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                code = WADDR_W'(i + 1);
            end
        end
    end

    assign clr = vec & (~vec + PEND_W'(1));

endmodule

// File: rtl/word_encoder_seq.sv
// rtl/word_encoder_seq.sv - serialises a word-enable mask into ascending word codes
module word_encoder_seq
    import word_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [WORDS-1:0]   load_mask,
    output logic               load_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WADDR_W-1:0] out_addr,
    output logic               out_last,
    output logic [WADDR_W-1:0] remaining,
    output logic               done,
    output logic               bad_bit7
);

    state_t              state, state_nxt;
    logic [PEND_W-1:0]   pend, pend_nxt;
    logic                done_nxt, bad_nxt;
    logic [WADDR_W-1:0]  low_code;
    logic [PEND_W-1:0]   low_clr;
    logic [WADDR_W-1:0]  cnt;
    logic                one_left;

    word_prienc u_prienc (
        .vec  (pend),
        .code (low_code),
        .clr  (low_clr)
    );

    always_comb begin
        cnt = '0;
        for (int i = 0; i < PEND_W; i++) begin
            cnt = cnt + WADDR_W'(pend[i]);
        end
    end

    assign one_left   = (cnt == WADDR_W'(1));
    assign load_ready = (state == IDLE);
    assign out_valid  = (state == RUN);
    assign out_addr   = out_valid ? low_code : WORD_NONE;
    assign out_last   = out_valid && one_left;
    assign remaining  = out_valid ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend     <= '0;
            done     <= 1'b0;
            bad_bit7 <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            done     <= done_nxt;
            bad_bit7 <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        done_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    pend_nxt = load_mask[PEND_W-1:0];
                    bad_nxt  = load_mask[WORDS-1];
                    if (|load_mask[PEND_W-1:0]) begin
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // Flush wins over a same-cycle transfer; that word is dropped unsent.
                if (flush) begin
                    pend_nxt  = '0;
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    pend_nxt = pend & ~low_clr;
                    if (one_left) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pend_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_word_encoder_seq.sv
// tb/tb_word_encoder_seq.sv - directed scoreboard bench for word_encoder_seq
module tb_word_encoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_mask;
    logic       load_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_addr;
    logic       out_last;
    logic [2:0] remaining;
    logic       done;
    logic       bad_bit7;

    typedef struct {
        logic [2:0] code;
        logic [2:0] rem;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    word_encoder_seq dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .remaining  (remaining),
        .done       (done),
        .bad_bit7   (bad_bit7)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [7:0] m);
        int total = 0;
        int idx   = 0;
        exp_t e;
        for (int k = 0; k < 7; k++) if (m[k]) total++;
        for (int k = 0; k < 7; k++) begin
            if (m[k]) begin
                e.code = 3'(k + 1);
                e.rem  = 3'(total - idx);
                e.last = (idx == total - 1);
                exp_q.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load_ready"}, {7'd0, load_ready}, 8'd1);
        check({tag, "_out_valid"},  {7'd0, out_valid},  8'd0);
        check({tag, "_out_addr"},   {5'd0, out_addr},   8'd0);
        check({tag, "_out_last"},   {7'd0, out_last},   8'd0);
        check({tag, "_remaining"},  {5'd0, remaining},  8'd0);
    endtask

    task automatic do_load(input logic [7:0] m, input logic fl);
        check("load_ready_before_load", {7'd0, load_ready}, 8'd1);
        load_valid = 1'b1;
        load_mask  = m;
        flush      = fl;
        push_expected(m);
        tick();
        load_valid = 1'b0;
        flush      = 1'b0;
        check("bad_bit7_with_load", {7'd0, bad_bit7}, {7'd0, m[7]});
    endtask

    // Drains the scoreboard; a stalled word is compared again every cycle to prove it holds.
    task automatic stream(input bit toggle, input bit junk_load);
        int cyc = 0;
        bit r   = 1'b1;
        while (exp_q.size() > 0 && cyc < 40) begin
            out_ready  = r;
            load_valid = junk_load;
            load_mask  = 8'h03;
            check("out_valid",     {7'd0, out_valid},  8'd1);
            check("load_ready_run",{7'd0, load_ready}, 8'd0);
            check("out_addr",      {5'd0, out_addr},   {5'd0, exp_q[0].code});
            check("remaining",     {5'd0, remaining},  {5'd0, exp_q[0].rem});
            check("out_last",      {7'd0, out_last},   {7'd0, exp_q[0].last});
            check("done_in_run",   {7'd0, done},       8'd0);
            if (r) void'(exp_q.pop_front());
            tick();
            cyc++;
            if (toggle) r = ~r;
        end
        check("stream_words_left", 8'(exp_q.size()), 8'd0);
        load_valid = 1'b0;
        out_ready  = 1'b1;
        check("done_after_last", {7'd0, done}, 8'd1);
        check_idle_outputs("after_last");
        tick();
        check("done_one_cycle", {7'd0, done},     8'd0);
        check("bad_bit7_clear", {7'd0, bad_bit7}, 8'd0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_mask  = 8'h00;
        flush      = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset");
        check("reset_done", {7'd0, done},     8'd0);
        check("reset_bad",  {7'd0, bad_bit7}, 8'd0);

        // Empty line
        out_ready = 1'b1;
        do_load(8'h00, 1'b0);
        check("empty_done", {7'd0, done}, 8'd1);
        check_idle_outputs("empty");
        tick();
        check("empty_done_clear", {7'd0, done},       8'd0);
        check("empty_ready",      {7'd0, load_ready}, 8'd1);

        // Sparse mask, full throughput
        do_load(8'h25, 1'b0);
        stream(1'b0, 1'b0);

        // Full mask with stalls; loads offered during RUN must be ignored
        do_load(8'h7F, 1'b0);
        stream(1'b1, 1'b1);

        // Bit 7 discarded, reported
        do_load(8'h81, 1'b0);
        stream(1'b0, 1'b0);

        // Flush beats a same-cycle transfer
        do_load(8'h0E, 1'b0);
        check("flush_first_code", {5'd0, out_addr}, 8'd2);
        out_ready = 1'b1;
        tick();
        check("flush_second_code", {5'd0, out_addr},  8'd3);
        check("flush_second_rem",  {5'd0, remaining}, 8'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check_idle_outputs("after_flush");
        check("flush_no_done", {7'd0, done}, 8'd0);
        tick();
        check("flush_no_done_later", {7'd0, done}, 8'd0);

        // Flush in IDLE is ignored and the simultaneous load proceeds
        do_load(8'h40, 1'b1);
        stream(1'b0, 1'b0);

        // Reset mid-sequence
        do_load(8'h18, 1'b0);
        out_ready  = 1'b1;
        load_valid = 1'b1;
        load_mask  = 8'h7F;
        check("rst_first_code", {5'd0, out_addr}, 8'd4);
        tick();
        check("rst_second_code", {5'd0, out_addr},  8'd5);
        check("rst_second_rem",  {5'd0, remaining}, 8'd1);
        check("rst_second_last", {7'd0, out_last},  8'd1);
        rst        = 1'b1;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        tick();
        exp_q.delete();
        check_idle_outputs("mid_reset");
        check("mid_reset_done", {7'd0, done},     8'd0);
        check("mid_reset_bad",  {7'd0, bad_bit7}, 8'd0);
        rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");
        check("post_reset_done", {7'd0, done}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
